// File: rtl/vga_pattern_switch_if.sv
// Video bundle between the pattern generator and its consumer: user
// colour/mode inputs towards the generator, syncs, enable and colour back.
interface vga_pattern_switch_if #(
    parameter int COLOR_W = 4
);
    logic [COLOR_W-1:0] sw_red;
    logic [COLOR_W-1:0] sw_green;
    logic [COLOR_W-1:0] sw_blue;
    logic [1:0]         mode;
    logic               h_sync;
    logic               v_sync;
    logic [COLOR_W-1:0] r_port;
    logic [COLOR_W-1:0] g_port;
    logic [COLOR_W-1:0] b_port;
    logic               DE;
    logic               frame_start;

    modport master (
        output sw_red, sw_green, sw_blue, mode,
        input  h_sync, v_sync, r_port, g_port, b_port, DE, frame_start
    );

    modport slave (
        input  sw_red, sw_green, sw_blue, mode,
        output h_sync, v_sync, r_port, g_port, b_port, DE, frame_start
    );
endinterface

// File: rtl/vga_pattern_switch.sv
// VGA timing generator with four selectable test patterns; mode and colour
// are sampled once per frame so a frame never mixes two patterns.
module vga_pattern_switch #(
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 4,
    parameter int COLOR_W    = 4,
    parameter bit SYNC_POL   = 1'b0,
    parameter int CHK_SHIFT  = 5,
    parameter int GRAD_SHIFT = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    vga_pattern_switch_if.slave   vga
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]   r_div;
    logic [HW-1:0]      r_x;
    logic [VW-1:0]      r_y;
    logic [1:0]         r_mode;
    logic [COLOR_W-1:0] r_sw_r, r_sw_g, r_sw_b;
    logic               r_hs, r_vs, r_de, r_fs;
    logic [COLOR_W-1:0] r_r, r_g, r_b;

    logic               w_tick, w_frame, w_latch;
    logic [1:0]         w_mode;
    logic [COLOR_W-1:0] w_sw_r, w_sw_g, w_sw_b;
    logic               w_hs, w_vs, w_de, w_chk;
    logic [2:0]         w_bar, w_bar_rgb;
    logic [COLOR_W-1:0] w_grad, w_r, w_g, w_b;

    // Pixel tick and frame-start detection
    always_comb begin
        w_tick  = (CLK_DIV == 1) ? 1'b1 : (r_div == DIV_W'(CLK_DIV - 1));
        w_frame = (r_x == {HW{1'b0}}) && (r_y == {VW{1'b0}});
        w_latch = w_tick && w_frame;
    end

    // Pixel clock divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_div <= {DIV_W{1'b0}};
        else if (w_tick) r_div <= {DIV_W{1'b0}};
        else             r_div <= r_div + DIV_W'(1);
    end

    // Raster position counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= {HW{1'b0}};
            r_y <= {VW{1'b0}};
        end else if (w_tick) begin
            if (r_x == HW'(H_TOT - 1)) begin
                r_x <= {HW{1'b0}};
                r_y <= (r_y == VW'(V_TOT - 1)) ? {VW{1'b0}} : r_y + VW'(1);
            end else begin
                r_x <= r_x + HW'(1);
            end
        end
    end

    // Per-frame shadow copy of the user selection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode <= 2'd0;
            r_sw_r <= {COLOR_W{1'b0}};
            r_sw_g <= {COLOR_W{1'b0}};
            r_sw_b <= {COLOR_W{1'b0}};
        end else if (w_latch) begin
            r_mode <= vga.mode;
            r_sw_r <= vga.sw_red;
            r_sw_g <= vga.sw_green;
            r_sw_b <= vga.sw_blue;
        end
    end

    // The first pixel of a frame must already show the newly sampled selection
    always_comb begin
        w_mode = w_frame ? vga.mode     : r_mode;
        w_sw_r = w_frame ? vga.sw_red   : r_sw_r;
        w_sw_g = w_frame ? vga.sw_green : r_sw_g;
        w_sw_b = w_frame ? vga.sw_blue  : r_sw_b;
    end

    // Sync/enable decode and pattern colour for the current position
    always_comb begin
        w_hs = ((r_x >= HW'(H_VIS + H_FP)) && (r_x < HW'(H_VIS + H_FP + H_SYNC)))
               ? SYNC_POL : ~SYNC_POL;
        w_vs = ((r_y >= VW'(V_VIS + V_FP)) && (r_y < VW'(V_VIS + V_FP + V_SYNC)))
               ? SYNC_POL : ~SYNC_POL;
        w_de = (r_x < HW'(H_VIS)) && (r_y < VW'(V_VIS));
        // bar index = x*8/H_VIS, counted as the thresholds x*8 has passed
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({r_x, 3'b000} >= (HW + 3)'(k * H_VIS)) w_bar = w_bar + 3'd1;
            else                                       w_bar = w_bar;
        end
        w_bar_rgb = {~w_bar[1], ~w_bar[2], ~w_bar[0]};
        w_chk     = r_x[CHK_SHIFT] ^ r_y[CHK_SHIFT];
        w_grad    = COLOR_W'(r_x >> GRAD_SHIFT);
        w_r = {COLOR_W{1'b0}};
        w_g = {COLOR_W{1'b0}};
        w_b = {COLOR_W{1'b0}};
        if (w_de) begin
            case (w_mode)
                2'd0: begin
                    w_r = w_sw_r; w_g = w_sw_g; w_b = w_sw_b;
                end
                2'd1: begin
                    w_r = {COLOR_W{w_bar_rgb[2]}};
                    w_g = {COLOR_W{w_bar_rgb[1]}};
                    w_b = {COLOR_W{w_bar_rgb[0]}};
                end
                2'd2: begin
                    if (w_chk) begin
                        w_r = w_sw_r; w_g = w_sw_g; w_b = w_sw_b;
                    end else begin
                        w_r = {COLOR_W{1'b0}};
                        w_g = {COLOR_W{1'b0}};
                        w_b = {COLOR_W{1'b0}};
                    end
                end
                2'd3: begin
                    w_r = w_grad; w_g = w_grad; w_b = w_grad;
                end
                default: begin
                    w_r = {COLOR_W{1'b0}};
                    w_g = {COLOR_W{1'b0}};
                    w_b = {COLOR_W{1'b0}};
                end
            endcase
        end else begin
            w_r = {COLOR_W{1'b0}};
            w_g = {COLOR_W{1'b0}};
            w_b = {COLOR_W{1'b0}};
        end
    end

    // Registered outputs, one pixel behind the counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs <= ~SYNC_POL;
            r_vs <= ~SYNC_POL;
            r_de <= 1'b0;
            r_fs <= 1'b0;
            r_r  <= {COLOR_W{1'b0}};
            r_g  <= {COLOR_W{1'b0}};
            r_b  <= {COLOR_W{1'b0}};
        end else begin
            r_fs <= w_latch;
            if (w_tick) begin
                r_hs <= w_hs;
                r_vs <= w_vs;
                r_de <= w_de;
                r_r  <= w_r;
                r_g  <= w_g;
                r_b  <= w_b;
            end
        end
    end

    assign vga.h_sync      = r_hs;
    assign vga.v_sync      = r_vs;
    assign vga.DE          = r_de;
    assign vga.frame_start = r_fs;
    assign vga.r_port      = r_r;
    assign vga.g_port      = r_g;
    assign vga.b_port      = r_b;
endmodule
